// File: rtl/fir_pkg.sv
// Shared constants and types for the time-multiplexed 63-tap FIR controller.
package fir_pkg;
  localparam int DATA_W  = 10;
  localparam int COEFF_W = 10;
  localparam int TAPS    = 63;
  localparam int OUT_W   = DATA_W + COEFF_W;
  localparam int ADDR_W  = $clog2(TAPS);
  localparam int ACC_W   = DATA_W + COEFF_W + $clog2(TAPS);

  typedef enum logic [1:0] {IDLE, MAC, DONE} fir_state_t;

  typedef logic signed [DATA_W-1:0]  sample_t;
  typedef logic signed [COEFF_W-1:0] coef_t;
  typedef logic signed [ACC_W-1:0]   acc_t;
  typedef logic signed [OUT_W-1:0]   out_t;
  typedef logic        [ADDR_W-1:0]  tap_idx_t;
endpackage

// File: rtl/fir_mac_unit.sv
// Registered signed multiply-accumulate; clr has priority over en.
module fir_mac_unit
  import fir_pkg::*;
(
  input  logic    clk,
  input  logic    rst,
  input  logic    clr,
  input  logic    en,
  input  sample_t a,
  input  coef_t   b,
  output acc_t    acc
);
  acc_t acc_d, acc_q;
  out_t prod;

  always_comb begin
    prod  = a * b;
    acc_d = acc_q;
    if (clr)     acc_d = '0;
    else if (en) acc_d = acc_q + {{(ACC_W-OUT_W){prod[OUT_W-1]}}, prod};
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) acc_q <= '0;
    else      acc_q <= acc_d;
  end

  assign acc = acc_q;
endmodule

// File: rtl/fir_mac_seq.sv
// FIR sequencer: sample ring, coefficient RAM, tap sweep through one MAC, result narrowing.
// Optional clamp of the result to OUT_W is enabled with `define FIR_SAT_EN.
module fir_mac_seq
  import fir_pkg::*;
(
  input  logic               clk,
  input  logic               rst,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [DATA_W-1:0]  in_data,
  input  logic               coef_we,
  input  logic [ADDR_W-1:0]  coef_addr,
  input  logic [COEFF_W-1:0] coef_wdata,
  output logic               out_valid,
  output logic [OUT_W-1:0]   out_data,
  output logic               busy
);
  fir_state_t state_q, state_d;
  tap_idx_t   wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d, k_q, k_d;
  sample_t    hist_q [TAPS];
  sample_t    hist_d [TAPS];
  coef_t      coef_q [TAPS];
  coef_t      coef_d [TAPS];
  logic       out_valid_q, out_valid_d;
  out_t       out_data_q, out_data_d, narrowed;
  logic       accept, last_tap;
  acc_t       acc;

  assign accept   = (state_q == IDLE) && in_valid;
  assign last_tap = (k_q == tap_idx_t'(TAPS-1));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state_q <= IDLE;
    else      state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:    if (accept)   state_d = MAC;
      MAC:     if (last_tap) state_d = DONE;
      DONE:                  state_d = IDLE;
      default:               state_d = IDLE;
    endcase
  end

  always_comb begin
    in_ready    = (state_q == IDLE);
    busy        = (state_q != IDLE);
    out_valid_d = (state_q == DONE);
    out_data_d  = (state_q == DONE) ? narrowed : out_data_q;
  end

  // rd_ptr walks backwards from the newest sample so no modulo subtract is needed.
  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    k_d      = k_q;
    hist_d   = hist_q;
    coef_d   = coef_q;
    if (state_q == IDLE && coef_we && coef_addr < tap_idx_t'(TAPS))
      coef_d[coef_addr] = coef_t'(coef_wdata);
    if (accept) begin
      hist_d[wr_ptr_q] = sample_t'(in_data);
      rd_ptr_d         = wr_ptr_q;
      k_d              = '0;
    end else if (state_q == MAC) begin
      k_d      = k_q + tap_idx_t'(1);
      rd_ptr_d = (rd_ptr_q == '0) ? tap_idx_t'(TAPS-1) : rd_ptr_q - tap_idx_t'(1);
      if (last_tap)
        wr_ptr_d = (wr_ptr_q == tap_idx_t'(TAPS-1)) ? '0 : wr_ptr_q + tap_idx_t'(1);
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q    <= '0;
      rd_ptr_q    <= '0;
      k_q         <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      for (int i = 0; i < TAPS; i++) begin
        hist_q[i] <= '0;
        coef_q[i] <= '0;
      end
    end else begin
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      k_q         <= k_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      hist_q      <= hist_d;
      coef_q      <= coef_d;
    end
  end

  fir_mac_unit u_mac (
    .clk (clk),
    .rst (rst),
    .clr (accept),
    .en  (state_q == MAC),
    .a   (hist_q[rd_ptr_q]),
    .b   (coef_q[k_q]),
    .acc (acc)
  );

`ifdef FIR_SAT_EN
  // Overflow iff the bits above the result sign are not a pure sign extension.
  always_comb begin
    if (acc[ACC_W-1:OUT_W-1] == '0 || acc[ACC_W-1:OUT_W-1] == '1)
      narrowed = acc[OUT_W-1:0];
    else if (acc[ACC_W-1])
      narrowed = {1'b1, {(OUT_W-1){1'b0}}};
    else
      narrowed = {1'b0, {(OUT_W-1){1'b1}}};
  end
`else
  logic unused_acc_hi;
  assign unused_acc_hi = ^acc[ACC_W-1:OUT_W];
  assign narrowed      = acc[OUT_W-1:0];
`endif

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
endmodule

// File: tb/tb_fir_mac_seq.sv
// Directed bench for fir_mac_seq: reset, impulse, DC, overflow, hold-off, mid-sweep reset.
module tb_fir_mac_seq;
  localparam int TAPS = 63;

  logic               clk = 1'b0;
  logic               rst;
  logic               in_valid;
  logic               in_ready;
  logic [9:0]         in_data;
  logic               coef_we;
  logic [5:0]         coef_addr;
  logic [9:0]         coef_wdata;
  logic               out_valid;
  logic signed [19:0] out_data;
  logic               busy;

  int vectors = 0;
  int miscompares = 0;

  fir_mac_seq dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_data    (in_data),
    .coef_we    (coef_we),
    .coef_addr  (coef_addr),
    .coef_wdata (coef_wdata),
    .out_valid  (out_valid),
    .out_data   (out_data),
    .busy       (busy)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input longint got, input longint exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // mode 0: coef[k]=k+1, mode 1: all 1, mode 2: all 511
  task automatic load_coefs(input int mode);
    for (int k = 0; k < TAPS; k++) begin
      coef_we    = 1'b1;
      coef_addr  = 6'(k);
      coef_wdata = (mode == 0) ? 10'(k + 1) : (mode == 1) ? 10'd1 : 10'd511;
      @(negedge clk);
    end
    coef_we = 1'b0;
  endtask

  // Offer one sample, wait for its result; lat = negedges from the accepting edge to the strobe.
  task automatic push(input logic [9:0] s, output longint res, output int lat);
    int n;
    n = 0;
    while (!in_ready && n < 200) begin @(negedge clk); n++; end
    in_valid = 1'b1;
    in_data  = s;
    @(negedge clk);
    in_valid = 1'b0;
    lat = 0;
    while (!out_valid && lat < 200) begin @(negedge clk); lat++; end
    res = out_data;
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst = 1'b0;
    repeat (3) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
  endtask

  initial begin
    longint r;
    int lat, lo, n, extra;
    rst = 1'b0; in_valid = 1'b0; in_data = '0;
    coef_we = 1'b0; coef_addr = '0; coef_wdata = '0;

    // 1. reset state
    repeat (3) @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_out_data", out_data, 0);
    chk("rst_busy", busy, 0);
    chk("rst_in_ready", in_ready, 1);
    rst = 1'b1;
    @(negedge clk);

    // 2. impulse response
    load_coefs(0);
    for (int i = 0; i < 65; i++) begin
      push((i == 0) ? 10'd1 : 10'd0, r, lat);
      chk($sformatf("impulse_%0d", i), r, (i < TAPS) ? i + 1 : 0);
      if (i == 0) chk("impulse_latency", lat, TAPS + 1);
    end

    // 3. DC response (history is all zero after the impulse run)
    load_coefs(1);
    for (int i = 0; i < TAPS; i++) begin
      push(10'd511, r, lat);
      chk($sformatf("dc_%0d", i), r, 511 * (i + 1));
    end

    // 4. overflow: history already holds 63 x 511, so every result is the full sum
    load_coefs(2);
    for (int i = 0; i < TAPS; i++) begin
      push(10'd511, r, lat);
`ifdef FIR_SAT_EN
      chk($sformatf("ovf_%0d", i), r, 524287);
`else
      chk($sformatf("ovf_%0d", i), r, -326593);
`endif
    end

    // 5. hold-off: in_valid held through the sweep, stray coef write mid-sweep
    do_reset();
    load_coefs(0);
    in_valid = 1'b1;
    in_data  = 10'd2;
    @(negedge clk);
    lo = 0; n = 0;
    while (!out_valid && n < 200) begin
      if (!in_ready) lo++;
      coef_we    = (n == 10);
      coef_addr  = 6'd0;
      coef_wdata = 10'd99;
      @(negedge clk);
      n++;
    end
    coef_we  = 1'b0;
    in_valid = 1'b0;
    chk("hold_ready_low_cycles", lo, TAPS + 1);
    chk("hold_latency", n, TAPS + 1);
    chk("hold_ready_at_strobe", in_ready, 1);
    chk("hold_result", out_data, 2);
    extra = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid || busy) extra++;
    end
    chk("hold_single_consume", extra, 0);
    push(10'd1, r, lat);
    chk("hold_coef_unchanged", r, 1 * 1 + 2 * 2);

    // 6. reset mid-sweep
    do_reset();
    load_coefs(0);
    in_valid = 1'b1;
    in_data  = 10'd5;
    @(negedge clk);
    in_valid = 1'b0;
    repeat (30) @(negedge clk);
    chk("midrst_busy_before", busy, 1);
    rst = 1'b0;
    @(negedge clk);
    chk("midrst_busy", busy, 0);
    chk("midrst_out_valid", out_valid, 0);
    chk("midrst_in_ready", in_ready, 1);
    chk("midrst_out_data", out_data, 0);
    @(negedge clk);
    rst = 1'b1;
    extra = 0;
    repeat (70) begin
      @(negedge clk);
      if (out_valid) extra++;
    end
    chk("midrst_no_strobe", extra, 0);
    load_coefs(0);
    for (int i = 0; i < 65; i++) begin
      push((i == 0) ? 10'd1 : 10'd0, r, lat);
      chk($sformatf("midrst_impulse_%0d", i), r, (i < TAPS) ? i + 1 : 0);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end
endmodule
